// File: rtl/note_envelope_pkg.sv
// Shared types and constants for the ADSR envelope stage that sits between
// the tone LUT and the I2S output.
package note_envelope_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Note codes at or above this value mean silence (gate off).
  localparam int NOTE_COUNT = 12;

endpackage

// File: rtl/env_scale.sv
// Registered amplitude scaler: y_out = (y_in * level) >>> level_width,
// updated only on the per-sample tick.
module env_scale #(
  parameter int y_width     = 16,
  parameter int level_width = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tick,
  input  logic signed [y_width-1:0]   y_in,
  input  logic [level_width-1:0]      level,
  output logic signed [y_width-1:0]   y_out
);

  // Level is unsigned, so a zero sign bit is prepended before the signed multiply.
  logic signed [y_width+level_width:0] product;

  assign product = y_in * $signed({1'b0, level});

  // NOTE: sequential state is written with non-blocking (<=) assignments only,
  // so every flop samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      y_out <= '0;
    end else if (tick) begin
      y_out <= y_width'(product >>> level_width);
    end
  end

endmodule

// File: rtl/note_envelope.sv
// ADSR amplitude envelope: gate derived from the note code, level stepped
// once per sample tick, sample scaled by the pre-update level.
module note_envelope
  import note_envelope_pkg::*;
#(
  parameter int y_width       = 16,
  parameter int note_width    = 4,
  parameter int level_width   = 8,
  parameter int attack_step   = 8,
  parameter int decay_step    = 2,
  parameter int sustain_level = 160,
  parameter int release_step  = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_tick,
  input  logic [note_width-1:0]       note,
  input  logic signed [y_width-1:0]   y_in,
  output logic signed [y_width-1:0]   y_out,
  output logic [level_width-1:0]      level,
  output logic                        busy
);

  localparam logic [level_width:0] FULL = {1'b0, {level_width{1'b1}}};
  localparam logic [level_width:0] ATT  = (level_width + 1)'(attack_step);
  localparam logic [level_width:0] DEC  = (level_width + 1)'(decay_step);
  localparam logic [level_width:0] REL  = (level_width + 1)'(release_step);
  localparam logic [level_width:0] SUS  = (level_width + 1)'(sustain_level);

  env_state_t             state, state_nxt;
  logic [level_width-1:0] level_nxt;
  logic [note_width-1:0]  note_q;
  logic                   gate, retrigger;

  // One bit of headroom so add/subtract results expose overflow and borrow.
  logic [level_width:0]   lvl_ext, lvl_up, lvl_dec, lvl_rel;

  assign gate      = (32'(note) < NOTE_COUNT);
  assign retrigger = gate && ((state == IDLE) || (state == RELEASE) || (note != note_q));
  assign busy      = (state != IDLE);

  assign lvl_ext = {1'b0, level};
  assign lvl_up  = lvl_ext + ATT;
  assign lvl_dec = lvl_ext - DEC;
  assign lvl_rel = lvl_ext - REL;

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (!gate && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nxt = RELEASE;
    end else if (retrigger) begin
      state_nxt = ATTACK;
    end else begin
      unique case (state)
        ATTACK: begin
          if (lvl_up >= FULL) begin
            level_nxt = FULL[level_width-1:0];
            state_nxt = DECAY;
          end else begin
            level_nxt = lvl_up[level_width-1:0];
          end
        end
        DECAY: begin
          // MSB set means the subtraction borrowed past zero.
          if (lvl_dec[level_width] || (lvl_dec <= SUS)) begin
            level_nxt = SUS[level_width-1:0];
            state_nxt = SUSTAIN;
          end else begin
            level_nxt = lvl_dec[level_width-1:0];
          end
        end
        SUSTAIN: level_nxt = level;
        RELEASE: begin
          if (lvl_rel[level_width] || (lvl_rel == '0)) begin
            level_nxt = '0;
            state_nxt = IDLE;
          end else begin
            level_nxt = lvl_rel[level_width-1:0];
          end
        end
        default: level_nxt = '0;
      endcase
    end
  end

  // NOTE: only control registers are reset; there is no storage array here
  // that would need clearing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      level  <= '0;
      note_q <= '0;
    end else if (sample_tick) begin
      state  <= state_nxt;
      level  <= level_nxt;
      note_q <= note;
    end
  end

  env_scale #(
    .y_width     (y_width),
    .level_width (level_width)
  ) u_scale (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (sample_tick),
    .y_in    (y_in),
    .level   (level),
    .y_out   (y_out)
  );

endmodule
